// File: rtl/sigmoid_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sigmoid_arbiter_if
// Description : Bundle of request, LUT and response signals between the
//               sigmoid arbiter and its requesters, shared LUT and consumer.
//               slave  : arbiter side (drives req_ready, lut_addr, resp_*,
//                        busy)
//               master : environment side (drives req_valid, req_data,
//                        lut_result, resp_ready)
//   req_valid  [N_REQ]       : per-requester operand present
//   req_data   [N_REQ*WIDTH] : operand i in bits [i*WIDTH +: WIDTH]
//   req_ready  [N_REQ]       : one-hot accept strobe for the granted requester
//   lut_addr   [WIDTH]       : registered address to the shared sigmoid LUT
//   lut_result [WIDTH]       : combinational LUT data for lut_addr
//   resp_valid               : response available
//   resp_data  [WIDTH]       : sigmoid result
//   resp_id    [ID_W]        : requester that owns resp_data
//   resp_ready               : consumer accepts the response
//   busy                     : arbiter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface sigmoid_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) ();

    localparam int c_ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       lut_addr;
    logic [WIDTH-1:0]       lut_result;
    logic                   resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic [c_ID_W-1:0]      resp_id;
    logic                   resp_ready;
    logic                   busy;

    modport slave (
        input  req_valid,
        input  req_data,
        input  lut_result,
        input  resp_ready,
        output req_ready,
        output lut_addr,
        output resp_valid,
        output resp_data,
        output resp_id,
        output busy
    );

    modport master (
        output req_valid,
        output req_data,
        output lut_result,
        output resp_ready,
        input  req_ready,
        input  lut_addr,
        input  resp_valid,
        input  resp_data,
        input  resp_id,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/sigmoid_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sigmoid_arbiter
// Description : Round-robin arbiter that lets N_REQ requesters share one
//               combinational sigmoid LUT. One operand is accepted from
//               IDLE, its LUT address is registered, the LUT output is
//               captured one cycle later and held as a response until the
//               consumer takes it.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - sigmoid_arbiter_if.slave (requests, LUT, response,
//                      busy)
// Revision    : 1.0 - initial release
// ============================================================================
module sigmoid_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sigmoid_arbiter_if.slave  bus
);

    localparam int c_ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_ID_W-1:0] c_LAST_RST = c_ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_ID_W-1:0]   r_last_grant;
    logic [c_ID_W-1:0]   w_grant;
    logic [c_ID_W-1:0]   w_cand;
    logic                w_found;

    logic                w_accept;
    logic                w_capture;
    logic                w_release;
    logic [N_REQ-1:0]    w_req_ready;

    logic [WIDTH-1:0]    r_lut_addr;
    logic [WIDTH-1:0]    r_resp_data;
    logic [c_ID_W-1:0]   r_resp_id;
    logic                r_resp_valid;

    // ------------------------------------------------------------------
    // Round-robin search: candidates are visited starting one above the
    // previous winner and wrapping; the previous winner itself is the
    // last candidate, so a lone persistent requester is still served.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = c_ID_W'((int'(r_last_grant) + k) % N_REQ);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_req_ready = '0;
        case (r_state)
            IDLE: begin
                // rst gates the accept strobe so no requester sees a
                // handshake that the reset is about to discard.
                if (w_found && !rst) begin
                    w_accept    = 1'b1;
                    w_req_ready = N_REQ'(1) << w_grant;
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                w_capture   = 1'b1;
                w_state_nxt = RESPOND;
            end
            RESPOND: begin
                if (bus.resp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. lut_addr and resp_id only move on an accept,
    // so the LUT sees a stable address through LOOKUP and RESPOND.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_LAST_RST;
            r_lut_addr   <= '0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_lut_addr   <= bus.req_data[w_grant*WIDTH +: WIDTH];
                r_resp_id    <= w_grant;
            end
            if (w_capture) begin
                r_resp_data  <= bus.lut_result;
                r_resp_valid <= 1'b1;
            end else if (w_release) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready  = w_req_ready;
    assign bus.lut_addr   = r_lut_addr;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_id    = r_resp_id;
    assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/sigmoid_arbiter.md
SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the data width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits: bit i high means requester i presents an operand.
REQ-006 The block SHALL have port req_data, input, N_REQ*WIDTH bits: operand of requester i in bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port req_ready, output, N_REQ bits: bit i high means requester i's operand is accepted this cycle.
REQ-008 The block SHALL have port lut_addr, output, WIDTH bits: registered address driven to the shared sigmoid LUT.
REQ-009 The block SHALL have port lut_result, input, WIDTH bits: combinational LUT output for lut_addr.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a result is available.
REQ-011 The block SHALL have port resp_data, output, WIDTH bits: sigmoid result.
REQ-012 The block SHALL have port resp_id, output, clog2(N_REQ) bits: index of the requester owning resp_data.
REQ-013 The block SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOOKUP and RESPOND.
REQ-016 In IDLE with any req_valid bit set, the block SHALL grant the winner g, assert req_ready[g] combinationally in that cycle only, register req_data[g] into lut_addr and g into resp_id, and move to LOOKUP.
REQ-017 In IDLE with req_valid all zero, the block SHALL remain in IDLE, keep req_ready all zero and leave lut_addr unchanged.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod N_REQ and proceeds upward with wrap-around; the first set bit wins.
REQ-019 last_grant SHALL update to g on each grant.
REQ-020 At most one req_ready bit SHALL be high in any cycle, and never outside IDLE.
REQ-021 In LOOKUP, the block SHALL register lut_result into resp_data, set resp_valid, and move to RESPOND after exactly one cycle.
REQ-022 In RESPOND, resp_valid, resp_data and resp_id SHALL hold stable until a cycle in which resp_ready is high.
REQ-023 In a RESPOND cycle with resp_ready high, resp_valid SHALL clear at the next edge and the state SHALL return to IDLE.
REQ-024 Latency SHALL be two edges from the accept edge to resp_valid high, and minimum throughput one operand per 3 cycles with resp_ready held high.
REQ-025 req_valid changes while the block is not in IDLE SHALL be ignored, with no queuing inside the block.
REQ-026 A requester whose req_valid stays high but is not granted SHALL keep its data; it is not lost.
REQ-027 With all requesters continuously valid, grants SHALL cycle 0,1,...,N_REQ-1,0 after reset.
REQ-028 lut_addr SHALL change only on a grant, so the LUT address is stable for the whole LOOKUP and RESPOND period.

Reset
REQ-029 While rst is high, the block SHALL set state IDLE, lut_addr 0, resp_data 0, resp_id 0, resp_valid 0, req_ready all 0, busy 0 and last_grant N_REQ-1, so requester 0 has first priority.
REQ-030 An assertion of rst in LOOKUP or RESPOND SHALL abort the operation immediately and discard the pending result.
REQ-031 After rst deasserts, the first rising edge SHALL evaluate IDLE arbitration normally.

Verification (bench LUT stub: lut_result = lut_addr XOR 16'hFFFF)
REQ-032 The bench SHALL cover a single request: req_valid=0001, req_data[0]=16'hF900, resp_ready=1 -> req_ready=0001 for 1 cycle; 2 edges later resp_valid=1, resp_data=16'h06FF, resp_id=0; next edge resp_valid=0, busy=0.
REQ-033 The bench SHALL cover round-robin fairness: req_valid=1111 held and resp_ready=1 -> resp_id sequence 0,1,2,3,0 with one grant every 3 cycles.
REQ-034 The bench SHALL cover back-pressure: resp_ready=0 for 5 cycles in RESPOND -> resp_data/resp_id stable, req_ready=0000, busy=1; raising resp_ready -> IDLE on the next edge.
REQ-035 The bench SHALL cover wrap-around: last grant 3, req_valid=1010 -> grant 1; then req_valid=1001 -> grant 3 is skipped in favour of 0 only if 3 was the last grant; requester 3 wins next.
REQ-036 The bench SHALL cover mid-operation reset: rst pulsed during LOOKUP -> all outputs 0 immediately; after release with req_valid=1000 -> requester 0 has first priority, so grant 3 while req_ready=1000.
REQ-037 The bench SHALL cover boundary operands: req_data=16'h0000 and 16'hFFFF -> resp_data=16'hFFFF and 16'h0000 respectively.
